regfile_multiport: RTL and testbench

Parametrised integer register file that succeeds the fixed 32×32 single-write design. It provides NRD combinational read ports, two prioritised write ports, a hardwired-zero x0, an optional same-cycle write-to-read bypass, and a sequential clear engine that sweeps the array one entry per cycle on request. It sits between decode (read addresses) and writeback (write ports) in the CPU datapath.

---
 rtl/regfile_multiport.sv | 161 ++++++++++++++++
 tb/tb_regfile_multiport.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport
//
// Parametrised integer register file sitting between decode (read addresses)
// and writeback (write ports). Entry 0 is hardwired to zero.
//
// Parameters
//   XLEN  : register width in bits
//   NREGS : number of registers (power of two, >= 4)
//   NRD   : number of combinational read ports (1..4)
//
// Ports
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset; clears every entry and the FSM
//   rd_addr   : packed read addresses, port i at [i*AW +: AW]
//   rd_data   : packed read data, port i at [i*XLEN +: XLEN]
//   wr0_*     : write port 0 (lower priority)
//   wr1_*     : write port 1 (wins on an address collision with wr0)
//   clr_req   : level-sampled request for a full-array sweep clear
//   busy      : sweep in progress; writes are dropped while high
//   clr_done  : one-cycle pulse in the cycle after the last entry is cleared
//
// Build option
//   REGFILE_BYPASS_EN : when defined, a read port returns the write data of a
//                       matching write in the same cycle (wr1 over wr0).
//                       When undefined, reads show stored contents only.

module regfile_multiport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NRD*$clog2(NREGS)-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]             rd_data,
  input  logic                            wr0_en,
  input  logic [$clog2(NREGS)-1:0]        wr0_addr,
  input  logic [XLEN-1:0]                 wr0_data,
  input  logic                            wr1_en,
  input  logic [$clog2(NREGS)-1:0]        wr1_addr,
  input  logic [XLEN-1:0]                 wr1_data,
  input  logic                            clr_req,
  output logic                            busy,
  output logic                            clr_done
);

  localparam int            AW   = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic            done_nxt;
  logic            sweep_clr;

  logic [XLEN-1:0] regs [NREGS];

  logic            we0, we1;

  // busy comes straight from the state register, so clr_req has no
  // combinational path to any output.
  assign busy = (state == SWEEP);

  // A write commits only to a non-zero address while no sweep is running.
  assign we0 = wr0_en && (wr0_addr != '0) && !busy;
  assign we1 = wr1_en && (wr1_addr != '0) && !busy;

  // Clear FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      clr_done <= done_nxt;
    end
  end

  // Clear FSM: next state and sweep control
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    sweep_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = SWEEP;
          idx_nxt   = AW'(1);
        end
      end
      SWEEP: begin
        sweep_clr = 1'b1;
        if (idx == LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Storage. The sweep and the write ports never act on the same edge since
  // writes are gated by busy; wr1 is assigned last so it wins a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (sweep_clr) begin
        regs[idx] <= '0;
      end
      if (we0) begin
        regs[wr0_addr] <= wr0_data;
      end
      if (we1) begin
        regs[wr1_addr] <= wr1_data;
      end
    end
  end

  // Combinational read ports
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = rd_addr[g*AW +: AW];

    always_comb begin
      // Entry 0 is forced to zero on the read side as well, independent of
      // whatever the storage slot holds.
      data = (addr == '0) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
      // we0/we1 already exclude address 0 and the busy window.
      if (we0 && (wr0_addr == addr)) begin
        data = wr0_data;
      end
      if (we1 && (wr1_addr == addr)) begin
        data = wr1_data;
      end
`else
`endif
    end

    assign rd_data[g*XLEN +: XLEN] = data;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic                 clk;
  logic                 reset_n;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic                 wr0_en, wr1_en;
  logic [AW-1:0]        wr0_addr, wr1_addr;
  logic [XLEN-1:0]      wr0_data, wr1_data;
  logic                 clr_req;
  logic                 busy;
  logic                 clr_done;

  int vectors;
  int miscompares;
  int busy_cnt;
  int done_at;

  regfile_multiport #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  function automatic logic [31:0] rdp(input int i);
    return rd_data[i*XLEN +: XLEN];
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n  = 1'b1;
    wr0_en   = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en   = 1'b0; wr1_addr = '0; wr1_data = '0;
    clr_req  = 1'b0;
    set_rd(5'd1, 5'd2, 5'd3);

    // Asynchronous reset pulse in the middle of the first cycle.
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, clr_done}, 32'd0);
    check("rst_rd0", rdp(0), 32'd0);
    check("rst_rd1", rdp(1), 32'd0);
    check("rst_rd2", rdp(2), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    // x0 write is ignored, also in the same cycle.
    set_rd(5'd0, 5'd0, 5'd0);
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hDEADBEEF;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hDEADBEEF;
    #1;
    check("x0_same_cycle", rdp(0), 32'd0);
    tick();
    wr0_en = 1'b0; wr1_en = 1'b0;
    #1;
    check("x0_after", rdp(0), 32'd0);
    check("x0_after_p2", rdp(2), 32'd0);

    // Collision on x5: wr1 wins.
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h11111111;
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h22222222;
    tick();
    wr0_en = 1'b0; wr1_en = 1'b0;
    set_rd(5'd5, 5'd0, 5'd0);
    #1;
    check("collision_x5", rdp(0), 32'h22222222);

    // Multiport read of x1..x3.
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'd1;
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'd2;
    tick();
    wr1_en = 1'b0;
    wr0_addr = 5'd3; wr0_data = 32'd3;
    tick();
    wr0_en = 1'b0;
    set_rd(5'd1, 5'd2, 5'd3);
    #1;
    check("mp_port0", rdp(0), 32'd1);
    check("mp_port1", rdp(1), 32'd2);
    check("mp_port2", rdp(2), 32'd3);
    check("mp_packed_lo", rd_data[63:32], 32'd2);
    set_rd(5'd3, 5'd2, 5'd1);
    #1;
    check("mp_swap_p0", rdp(0), 32'd3);
    check("mp_swap_p2", rdp(2), 32'd1);

    // Bypass on x7, starting from a known old value.
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h12345678;
    tick();
    set_rd(5'd7, 5'd7, 5'd5);
    wr0_data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_p0", rdp(0), 32'hA5A5A5A5);
    check("bypass_p1", rdp(1), 32'hA5A5A5A5);
`else
    check("nobypass_p0", rdp(0), 32'h12345678);
    check("nobypass_p1", rdp(1), 32'h12345678);
`endif
    check("bypass_other", rdp(2), 32'h22222222);
    tick();
    wr0_en = 1'b0;
    #1;
    check("bypass_after", rdp(0), 32'hA5A5A5A5);

    // Both ports writing x7: wr1 has bypass priority.
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h0000AAAA;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h0000BBBB;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_prio", rdp(0), 32'h0000BBBB);
`else
    check("nobypass_prio", rdp(0), 32'hA5A5A5A5);
`endif
    tick();
    wr0_en = 1'b0; wr1_en = 1'b0;
    #1;
    check("prio_after", rdp(1), 32'h0000BBBB);

    // Fill x1..x31 with all ones.
    for (int r = 1; r < NREGS; r += 2) begin
      wr0_en = 1'b1; wr0_addr = AW'(r);     wr0_data = 32'hFFFFFFFF;
      wr1_en = (r + 1 < NREGS); wr1_addr = AW'(r + 1); wr1_data = 32'hFFFFFFFF;
      tick();
    end
    wr0_en = 1'b0; wr1_en = 1'b0;
    set_rd(5'd20, 5'd16, 5'd31);
    #1;
    check("fill_x16", rdp(1), 32'hFFFFFFFF);
    check("fill_x31", rdp(2), 32'hFFFFFFFF);

    // Sweep accepted at edge N.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("sweep_busy_n", {31'd0, busy}, 32'd1);
    check("sweep_done_n", {31'd0, clr_done}, 32'd0);
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= NREGS - 2; k++) begin
      // A write to x20 after it has been swept must stay dropped.
      wr0_en = (k == 26); wr0_addr = 5'd20; wr0_data = 32'h55555555;
      tick();
      if (busy) busy_cnt++;
      check("sweep_busy_k", {31'd0, busy}, 32'd1);
      check("sweep_done_k", {31'd0, clr_done}, 32'd0);
      if (k == 15) check("x16_before", rdp(1), 32'hFFFFFFFF);
      if (k == 16) check("x16_cleared", rdp(1), 32'd0);
      if (k == 30) check("x31_before", rdp(2), 32'hFFFFFFFF);
    end
    wr0_en = 1'b0;
    tick();
    check("sweep_end_busy", {31'd0, busy}, 32'd0);
    check("sweep_end_done", {31'd0, clr_done}, 32'd1);
    check("sweep_busy_cycles", busy_cnt, 32'd31);
    check("x31_cleared", rdp(2), 32'd0);
    check("x20_dropped", rdp(0), 32'd0);

    // New request in the clr_done cycle, with a write on the accepting edge.
    clr_req = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd30; wr0_data = 32'hCAFEBABE;
    set_rd(5'd20, 5'd16, 5'd30);
    tick();
    clr_req = 1'b0; wr0_en = 1'b0;
    check("resweep_busy", {31'd0, busy}, 32'd1);
    check("resweep_done_low", {31'd0, clr_done}, 32'd0);
    check("accept_edge_write", rdp(2), 32'hCAFEBABE);
    repeat (9) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_x30", rdp(2), 32'hCAFEBABE);

    // Reset mid-sweep, asserted just after edge N+10.
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, clr_done}, 32'd0);
    check("midrst_x30", rdp(2), 32'd0);
    tick();
    check("midrst_done_hold", {31'd0, clr_done}, 32'd0);
    #2 reset_n = 1'b1;
    tick();
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_done", {31'd0, clr_done}, 32'd0);

    // A fresh request runs a full sweep.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cnt++;
      if (clr_done) begin
        done_at = c;
        break;
      end
      tick();
    end
    check("full_sweep_busy", busy_cnt, 32'd31);
    check("full_sweep_done_at", done_at, 32'd31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
